xor_mem_port_scheduler: RTL and testbench

Front-end controller for the pipelined XOR-based multi-ported BRAM memory. It takes one valid/ready request stream per memory port, detects the address hazards that corrupt XOR-encoded contents, stalls offending requests, and drives the memory ports. It also returns read data with fixed latency and counts stall cycles. It sits between the client ports and the memory instance, one-to-one on port index.

---
 rtl/xor_mem_pkg.sv | 21 ++
 rtl/xor_mem_port_scheduler_if.sv | 37 +++
 rtl/xor_mem_hazard_check.sv | 34 +++
 rtl/xor_mem_port_scheduler.sv | 88 ++++++++
 tb/tb_xor_mem_port_scheduler.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/xor_mem_pkg.sv
// Shared types and sizing helpers for the XOR multi-port memory front end.
// Imported by the scheduler, its interface and the hazard checker.
package xor_mem_pkg;

  localparam int STALL_CNT_W = 32;
  localparam int WIDTH_DEF   = 32;
  localparam int DEPTH_DEF   = 1024;

  function automatic int aw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int AW_DEF = aw_of(DEPTH_DEF);

  typedef struct packed {
    logic                 we;
    logic [AW_DEF-1:0]    addr;
    logic [WIDTH_DEF-1:0] d;
  } req_t;

endpackage

// File: rtl/xor_mem_port_scheduler_if.sv
// Per-port client request/response and memory-side signals.
// The scheduler uses the slave view.
interface xor_mem_port_scheduler_if
  import xor_mem_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PORTS = 32
);
  localparam int AW = aw_of(DEPTH);

  logic [PORTS-1:0]            req_valid;
  logic [PORTS-1:0]            req_ready;
  logic [PORTS-1:0]            req_we;
  logic [PORTS-1:0][AW-1:0]    req_addr;
  logic [PORTS-1:0][WIDTH-1:0] req_d;
  logic [PORTS-1:0]            rsp_valid;
  logic [PORTS-1:0][WIDTH-1:0] rsp_data;
  logic [PORTS-1:0][AW-1:0]    mem_addr;
  logic [PORTS-1:0][WIDTH-1:0] mem_d;
  logic [PORTS-1:0]            mem_en;
  logic [PORTS-1:0][WIDTH-1:0] mem_q;

  modport master (
    output req_valid, req_we, req_addr,
    output req_d, mem_q,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_addr, mem_d, mem_en
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_d, mem_q,
    output req_ready, rsp_valid, rsp_data,
    output mem_addr, mem_d, mem_en
  );
endinterface

// File: rtl/xor_mem_hazard_check.sv
// Combinational per-port stall decision from this cycle's requests
// and the previous cycle's issued-write history.
module xor_mem_hazard_check
  import xor_mem_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int PORTS = 32
) (
  input  logic [PORTS-1:0]         valid,
  input  logic [PORTS-1:0]         we,
  input  logic [PORTS-1:0][AW-1:0] addr,
  input  logic [PORTS-1:0]         hist_v,
  input  logic [PORTS-1:0][AW-1:0] hist_addr,
  output logic [PORTS-1:0]         stall
);

  always_comb begin
    stall = '0;
    for (int i = 0; i < PORTS; i++) begin
      // write committing this cycle: every port on that row sees stale data
      for (int k = 0; k < PORTS; k++) begin
        if (hist_v[k] && hist_addr[k] == addr[i])
          stall[i] = 1'b1;
      end
      // same-cycle write collision: lowest port keeps the row
      for (int j = 0; j < i; j++) begin
        if (we[i] && valid[j] && we[j] &&
            addr[j] == addr[i])
          stall[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xor_mem_port_scheduler.sv
// Request scheduler in front of the XOR multi-port memory: hazard
// stalls, memory port drive, fixed-latency read return, stall counter.
module xor_mem_port_scheduler
  import xor_mem_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PORTS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  xor_mem_port_scheduler_if.slave bus,
  output logic [STALL_CNT_W-1:0] stall_count
);
  localparam int AW = aw_of(DEPTH);

  req_t req [PORTS];

  logic [PORTS-1:0]         we_v;
  logic [PORTS-1:0][AW-1:0] addr_v;
  logic [PORTS-1:0]         stall;
  logic [PORTS-1:0]         issue;
  logic [PORTS-1:0]         hist_v;
  logic [PORTS-1:0][AW-1:0] hist_addr;
  logic [PORTS-1:0]         rd_p1;
  logic [PORTS-1:0]         rd_p2;
  logic                     any_stall;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      req[i].we   = bus.req_we[i];
      req[i].addr = bus.req_addr[i];
      req[i].d    = bus.req_d[i];
      we_v[i]     = req[i].we;
      addr_v[i]   = req[i].addr;
      bus.mem_addr[i] = req[i].addr;
      bus.mem_d[i]    = req[i].d;
    end
  end

  xor_mem_hazard_check #(
    .AW    (AW),
    .PORTS (PORTS)
  ) u_hazard (
    .valid     (bus.req_valid),
    .we        (we_v),
    .addr      (addr_v),
    .hist_v    (hist_v),
    .hist_addr (hist_addr),
    .stall     (stall)
  );

  assign issue = bus.req_valid & ~stall & {PORTS{rst_n}};
  assign any_stall = |(bus.req_valid & stall);

  assign bus.req_ready = ~stall;
  assign bus.mem_en    = issue & we_v;
  assign bus.rsp_valid = rd_p2;
  assign bus.rsp_data  = bus.mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_v    <= '0;
      hist_addr <= '0;
    end else begin
      hist_v    <= issue & we_v;
      hist_addr <= addr_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1 <= '0;
      rd_p2 <= '0;
    end else begin
      rd_p1 <= issue & ~we_v;
      rd_p2 <= rd_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (any_stall && stall_count != '1)
      stall_count <= stall_count + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_xor_mem_port_scheduler.sv
// Directed bench for the XOR memory port scheduler with a pipelined
// memory model and a per-port response scoreboard.
module tb_xor_mem_port_scheduler;
  localparam int P = 4;
  localparam logic [9:0] NA = 10'h3FF;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [31:0] stall_count;

  xor_mem_port_scheduler_if #(
    .WIDTH (32), .DEPTH (1024), .PORTS (P)
  ) bus ();

  xor_mem_port_scheduler #(
    .WIDTH (32), .DEPTH (1024), .PORTS (P)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: read data out two edges after address,
  // writes land one edge after the write strobe edge
  logic [31:0] mem [1024];
  logic [P-1:0][31:0] rd1;
  logic [P-1:0][31:0] q2;
  bit   [P-1:0] pend_en;
  bit   [P-1:0][9:0] pend_a;
  bit   [P-1:0][31:0] pend_d;

  assign bus.mem_q = q2;

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] <= 32'h1000_0000 + i;
  end

  always @(posedge clk) begin
    for (int p = 0; p < P; p++) begin
      rd1[p] <= mem[bus.mem_addr[p]];
      q2[p]  <= rd1[p];
      if (pend_en[p])
        mem[pend_a[p]] <= pend_d[p];
    end
    pend_en <= bus.mem_en;
    pend_a  <= bus.mem_addr;
    pend_d  <= bus.mem_d;
  end

  logic [31:0] ref_mem [1024];
  exp_t sb [P][$];
  int tests;
  int fails;
  int cyc;
  int exp_stall;

  task automatic step(
    input logic [P-1:0]       v,
    input logic [P-1:0]       w,
    input logic [P-1:0][9:0]  a,
    input logic [P-1:0][31:0] d,
    input logic [P-1:0]       rdy
  );
    logic ev;
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_we    = w;
    bus.req_addr  = a;
    bus.req_d     = d;
    @(negedge clk);
    tests++;
    assert (bus.req_ready === rdy) else begin
      fails++;
      $error("FAIL ready cyc=%0d got=%b exp=%b",
             cyc, bus.req_ready, rdy);
    end
    tests++;
    assert (bus.mem_en === (v & w & rdy)) else begin
      fails++;
      $error("FAIL mem_en cyc=%0d got=%b exp=%b",
             cyc, bus.mem_en, v & w & rdy);
    end
    tests++;
    assert (stall_count === exp_stall) else begin
      fails++;
      $error("FAIL stall_count cyc=%0d got=%0d exp=%0d",
             cyc, stall_count, exp_stall);
    end
    for (int p = 0; p < P; p++) begin
      ev = 1'b0;
      if (sb[p].size() != 0)
        ev = (sb[p][0].due == cyc);
      tests++;
      assert (bus.rsp_valid[p] === ev) else begin
        fails++;
        $error("FAIL rsp_valid p%0d cyc=%0d got=%b exp=%b",
               p, cyc, bus.rsp_valid[p], ev);
      end
      if (ev) begin
        tests++;
        assert (bus.rsp_data[p] === sb[p][0].data) else begin
          fails++;
          $error("FAIL rsp_data p%0d cyc=%0d got=%h exp=%h",
                 p, cyc, bus.rsp_data[p], sb[p][0].data);
        end
        void'(sb[p].pop_front());
      end
    end
    for (int p = 0; p < P; p++)
      if (v[p] && rdy[p] && !w[p])
        sb[p].push_back('{cyc + 2, ref_mem[a[p]]});
    for (int p = 0; p < P; p++)
      if (v[p] && rdy[p] && w[p])
        ref_mem[a[p]] = d[p];
    if (|(v & ~rdy))
      exp_stall++;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step('0, '0, {NA, NA, NA, NA}, '0, 4'hF);
  endtask

  task automatic check_cnt(input int exp);
    tests++;
    assert (stall_count === exp) else begin
      fails++;
      $error("FAIL stall_total got=%0d exp=%0d",
             stall_count, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    assert (bus.rsp_valid === 4'h0) else begin
      fails++;
      $error("FAIL %s rsp_valid got=%b exp=0",
             tag, bus.rsp_valid);
    end
    tests++;
    assert (bus.mem_en === 4'h0) else begin
      fails++;
      $error("FAIL %s mem_en got=%b exp=0", tag, bus.mem_en);
    end
    tests++;
    assert (stall_count === 32'd0) else begin
      fails++;
      $error("FAIL %s stall_count got=%0d exp=0",
             tag, stall_count);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    exp_stall = 0;
    for (int i = 0; i < 1024; i++)
      ref_mem[i] = 32'h1000_0000 + i;
    rst_n = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_we    = 4'b0001;
    bus.req_addr  = {NA, NA, NA, 10'h20};
    bus.req_d     = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_reset_outputs("in_reset");
    end
    bus.req_valid = '0;
    bus.req_we    = '0;
    rst_n = 1'b1;

    // back-to-back reads on all ports
    for (int k = 0; k < 8; k++)
      step(4'hF, 4'h0,
           {10'h13, 10'h12, 10'h11, 10'h10}, '0, 4'hF);
    idle(2);
    check_cnt(0);

    // write then read next cycle on another port
    step(4'b0001, 4'b0001, {NA, NA, NA, 10'h20},
         {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 4'hF);
    step(4'b0100, 4'b0000, {NA, 10'h20, NA, NA},
         '0, 4'b1011);
    step(4'b0100, 4'b0000, {NA, 10'h20, NA, NA},
         '0, 4'hF);
    idle(3);
    check_cnt(1);

    // two writes to one row in one cycle
    step(4'b1010, 4'b1010, {10'h30, NA, 10'h30, NA},
         {32'h3333, 32'h0, 32'h1111, 32'h0}, 4'b0111);
    step(4'b1000, 4'b1000, {10'h30, NA, NA, NA},
         {32'h3333, 32'h0, 32'h0, 32'h0}, 4'b0111);
    step(4'b1000, 4'b1000, {10'h30, NA, NA, NA},
         {32'h3333, 32'h0, 32'h0, 32'h0}, 4'hF);
    idle(1);
    step(4'b0001, 4'b0000, {NA, NA, NA, 10'h30},
         '0, 4'hF);
    idle(2);
    check_cnt(3);

    // same-cycle read and write: read-first
    step(4'b0001, 4'b0001, {NA, NA, NA, 10'h40},
         {32'h0, 32'h0, 32'h0, 32'h5A}, 4'hF);
    idle(1);
    step(4'b0011, 4'b0001, {NA, NA, 10'h40, 10'h40},
         {32'h0, 32'h0, 32'h0, 32'hA5}, 4'hF);
    idle(1);
    step(4'b0100, 4'b0000, {NA, 10'h40, NA, NA},
         '0, 4'hF);
    idle(2);
    check_cnt(3);

    // same-port back-to-back writes
    step(4'b0001, 4'b0001, {NA, NA, NA, 10'h50},
         {32'h0, 32'h0, 32'h0, 32'h1}, 4'hF);
    step(4'b0001, 4'b0001, {NA, NA, NA, 10'h50},
         {32'h0, 32'h0, 32'h0, 32'h2}, 4'b1110);
    step(4'b0001, 4'b0001, {NA, NA, NA, 10'h50},
         {32'h0, 32'h0, 32'h0, 32'h2}, 4'hF);
    idle(1);
    step(4'b0001, 4'b0000, {NA, NA, NA, 10'h50},
         '0, 4'hF);
    idle(2);
    check_cnt(4);

    // reset in flight drops pending responses
    step(4'b0011, 4'b0000, {NA, NA, 10'h11, 10'h10},
         '0, 4'hF);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0001;
    bus.req_we    = 4'b0001;
    bus.req_addr  = {NA, NA, NA, 10'h60};
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    bus.req_valid = '0;
    bus.req_we    = '0;
    for (int p = 0; p < P; p++)
      sb[p].delete();
    exp_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    idle(3);
    check_cnt(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
